program_counter: RTL and testbench

- Program counter stage directly downstream of the CPU control FSM.
- Consumes the FSM's PC-enable strobe and advances, branches or jumps the instruction address.
- Evaluates CR16-style branch conditions against the processor status flags.
- Captures a link address for jump-and-link, and drives the instruction-memory address port.

---
 rtl/program_counter_if.sv | 34 +++
 rtl/program_counter.sv | 141 ++++++++++++++
 tb/tb_program_counter.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_counter_if.sv
//------------------------------------------------------------------------------
// program_counter_if : control-FSM to program-counter bus.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface program_counter_if #(
   parameter int unsigned ADDR_W = 16
);
   logic              pc_en;
   logic [1:0]        mode;
   logic [3:0]        cond;
   logic [4:0]        flags;
   logic [7:0]        disp;
   logic [ADDR_W-1:0] target;
   logic              link_en;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] pc_plus1;
   logic [ADDR_W-1:0] link;
   logic              taken;
   logic              fault;

   modport master (
      output pc_en, mode, cond, flags, disp, target, link_en,
      input  pc, pc_plus1, link, taken, fault
   );

   modport slave (
      input  pc_en, mode, cond, flags, disp, target, link_en,
      output pc, pc_plus1, link, taken, fault
   );
endinterface

`default_nettype wire

// File: rtl/program_counter.sv
//------------------------------------------------------------------------------
// program_counter : PC stage with CR16 branch conditions and jump-and-link.
// Optional bounds trap enabled by defining PC_BOUNDS_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module program_counter #(
   parameter int unsigned       ADDR_W     = 16,
   parameter logic [ADDR_W-1:0] RESET_ADDR = 16'h0000,
   parameter logic [ADDR_W-1:0] MAX_ADDR   = 16'h03FF,
   parameter logic [ADDR_W-1:0] TRAP_ADDR  = 16'h0000
) (
   input  wire logic            clk,
   input  wire logic            rst_n,
   program_counter_if.slave     bus
);

   localparam logic [1:0] c_MODE_INC  = 2'b00;
   localparam logic [1:0] c_MODE_BR   = 2'b01;
   localparam logic [1:0] c_MODE_JMP  = 2'b10;
   localparam logic [1:0] c_MODE_HOLD = 2'b11;

   logic [ADDR_W-1:0] pc_q,    pc_d;
   logic [ADDR_W-1:0] link_q,  link_d;
   logic              taken_q, taken_d;
   logic [ADDR_W-1:0] pc_inc;
   logic [ADDR_W-1:0] pc_rel;
   logic              cond_true;

   logic flag_c, flag_l, flag_f, flag_z, flag_n;
   assign {flag_c, flag_l, flag_f, flag_z, flag_n} = bus.flags;

   always_comb begin
      cond_true = 1'b0;
      unique case (bus.cond)
         4'b0000: cond_true =  flag_z;
         4'b0001: cond_true = !flag_z;
         4'b0010: cond_true =  flag_c;
         4'b0011: cond_true = !flag_c;
         4'b0100: cond_true =  flag_l;
         4'b0101: cond_true = !flag_l;
         4'b0110: cond_true =  flag_n;
         4'b0111: cond_true = !flag_n;
         4'b1000: cond_true =  flag_f;
         4'b1001: cond_true = !flag_f;
         4'b1010: cond_true = !flag_l && !flag_z;
         4'b1011: cond_true =  flag_l ||  flag_z;
         4'b1100: cond_true = !flag_n && !flag_z;
         4'b1101: cond_true =  flag_n ||  flag_z;
         4'b1110: cond_true = 1'b1;
         4'b1111: cond_true = 1'b0;
         default: cond_true = 1'b0;
      endcase
   end

   assign pc_inc = pc_q + ADDR_W'(1);
   assign pc_rel = pc_q + {{(ADDR_W-8){bus.disp[7]}}, bus.disp};

`ifdef PC_BOUNDS_EN
   logic fault_q, fault_d;
`endif

   always_comb begin
      pc_d    = pc_q;
      link_d  = link_q;
      taken_d = taken_q;
`ifdef PC_BOUNDS_EN
      fault_d = fault_q;
`endif
      if (bus.pc_en) begin
         unique case (bus.mode)
            c_MODE_INC: begin
               pc_d    = pc_inc;
               taken_d = 1'b0;
            end
            c_MODE_BR: begin
               pc_d    = cond_true ? pc_rel : pc_inc;
               taken_d = cond_true;
            end
            c_MODE_JMP: begin
               pc_d    = cond_true ? bus.target : pc_inc;
               taken_d = cond_true;
               if (cond_true && bus.link_en) begin
                  link_d = pc_inc;
               end
            end
            c_MODE_HOLD: begin
               taken_d = 1'b0;
            end
            default: begin
               taken_d = 1'b0;
            end
         endcase
`ifdef PC_BOUNDS_EN
         // Hold never computes a new address, so it cannot trap.
         if (bus.mode != c_MODE_HOLD && pc_d > MAX_ADDR) begin
            pc_d    = TRAP_ADDR;
            taken_d = 1'b1;
            fault_d = 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= RESET_ADDR;
         link_q  <= '0;
         taken_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         link_q  <= link_d;
         taken_q <= taken_d;
      end
   end

`ifdef PC_BOUNDS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault_q <= 1'b0;
      end else begin
         fault_q <= fault_d;
      end
   end

   assign bus.fault = fault_q;
`else
   logic unused_bounds;
   assign unused_bounds = ^{MAX_ADDR, TRAP_ADDR};
   assign bus.fault     = 1'b0;
`endif

   assign bus.pc       = pc_q;
   assign bus.pc_plus1 = pc_inc;
   assign bus.link     = link_q;
   assign bus.taken    = taken_q;

endmodule

`default_nettype wire

// File: tb/tb_program_counter.sv
//------------------------------------------------------------------------------
// tb_program_counter : randomized self-checking bench for program_counter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_program_counter;

   localparam logic [15:0] RESET_ADDR = 16'h0000;
   localparam logic [15:0] MAX_ADDR   = 16'h03FF;
   localparam logic [15:0] TRAP_ADDR  = 16'h0000;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_cmp  = 0;
   int   n_fail = 0;

   logic [15:0] m_pc;
   logic [15:0] m_link;
   logic        m_taken;
   logic        m_fault;

   program_counter_if #(.ADDR_W(16)) bus ();

   program_counter #(
      .ADDR_W     (16),
      .RESET_ADDR (RESET_ADDR),
      .MAX_ADDR   (MAX_ADDR),
      .TRAP_ADDR  (TRAP_ADDR)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic bit cond_holds(input logic [3:0] c, input logic [4:0] f);
      bit fc = f[4], fl = f[3], ff = f[2], fz = f[1], fn = f[0];
      case (c)
         4'd0:  return fz;
         4'd1:  return !fz;
         4'd2:  return fc;
         4'd3:  return !fc;
         4'd4:  return fl;
         4'd5:  return !fl;
         4'd6:  return fn;
         4'd7:  return !fn;
         4'd8:  return ff;
         4'd9:  return !ff;
         4'd10: return !fl && !fz;
         4'd11: return fl || fz;
         4'd12: return !fn && !fz;
         4'd13: return fn || fz;
         4'd14: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic void model_reset();
      m_pc = RESET_ADDR; m_link = 16'h0; m_taken = 1'b0; m_fault = 1'b0;
   endfunction

   function automatic void model_step(input logic [1:0] md, input logic [3:0] cd,
                                      input logic [4:0] fl, input logic [7:0] ds,
                                      input logic [15:0] tg, input logic le);
      int          d   = $signed(ds);
      logic [15:0] nxt = m_pc;
      bit          ok  = cond_holds(cd, fl);
      m_taken = 1'b0;
      if (md == 2'd0) nxt = m_pc + 16'd1;
      else if (md == 2'd1) begin
         nxt = ok ? 16'(int'(m_pc) + d) : m_pc + 16'd1;
         m_taken = ok;
      end else if (md == 2'd2) begin
         nxt = ok ? tg : m_pc + 16'd1;
         m_taken = ok;
         if (ok && le) m_link = m_pc + 16'd1;
      end
`ifdef PC_BOUNDS_EN
      if (md != 2'd3 && nxt > MAX_ADDR) begin
         nxt = TRAP_ADDR; m_taken = 1'b1; m_fault = 1'b1;
      end
`endif
      m_pc = nxt;
   endfunction

   task automatic pulse(input logic [1:0] md, input logic [3:0] cd, input logic [4:0] fl,
                        input logic [7:0] ds, input logic [15:0] tg, input logic le);
      @(negedge clk);
      bus.pc_en = 1'b1; bus.mode = md; bus.cond = cd; bus.flags = fl;
      bus.disp = ds; bus.target = tg; bus.link_en = le;
      @(posedge clk);
      model_step(md, cd, fl, ds, tg, le);
      #1 bus.pc_en = 1'b0;
   endtask

   task automatic set_pc(input logic [15:0] a);
      pulse(2'd2, 4'he, 5'h00, 8'h00, a, 1'b0);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      bus.pc_en = 1'b0; bus.mode = 2'd0; bus.cond = 4'd0; bus.flags = 5'd0;
      bus.disp = 8'd0; bus.target = 16'd0; bus.link_en = 1'b0;
      model_reset();
      #2;
      n_cmp++; if (bus.pc !== RESET_ADDR) begin n_fail++; $display("FAIL reset_pc: got %h want %h", bus.pc, RESET_ADDR); end
      n_cmp++; if (bus.link !== 16'h0) begin n_fail++; $display("FAIL reset_link: got %h want 0000", bus.link); end
      n_cmp++; if (bus.taken !== 1'b0) begin n_fail++; $display("FAIL reset_taken: got %b want 0", bus.taken); end
      n_cmp++; if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %b want 0", bus.fault); end
      n_cmp++; if (bus.pc_plus1 !== 16'h0001) begin n_fail++; $display("FAIL reset_pc_plus1: got %h want 0001", bus.pc_plus1); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++; if (bus.pc !== RESET_ADDR) begin n_fail++; $display("FAIL release_idle: got %h want %h", bus.pc, RESET_ADDR); end
   endtask

   task automatic test_increment();
      for (int i = 1; i <= 3; i++) begin
         pulse(2'd0, 4'd0, 5'd0, 8'd0, 16'd0, 1'b0);
         n_cmp++; if (bus.pc !== 16'(i)) begin n_fail++; $display("FAIL inc_pc%0d: got %h want %h", i, bus.pc, 16'(i)); end
         n_cmp++; if (bus.taken !== 1'b0) begin n_fail++; $display("FAIL inc_taken%0d: got %b want 0", i, bus.taken); end
      end
      repeat (5) @(posedge clk);
      #1;
      n_cmp++; if (bus.pc !== 16'h0003) begin n_fail++; $display("FAIL idle_hold: got %h want 0003", bus.pc); end
      n_cmp++; if (bus.pc_plus1 !== 16'h0004) begin n_fail++; $display("FAIL idle_plus1: got %h want 0004", bus.pc_plus1); end
   endtask

   task automatic test_branch();
      set_pc(16'h0010);
      pulse(2'd1, 4'd0, 5'b00010, 8'hF8, 16'd0, 1'b0);
      n_cmp++; if (bus.pc !== 16'h0008) begin n_fail++; $display("FAIL br_taken_pc: got %h want 0008", bus.pc); end
      n_cmp++; if (bus.taken !== 1'b1) begin n_fail++; $display("FAIL br_taken_flag: got %b want 1", bus.taken); end
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (bus.taken !== 1'b1) begin n_fail++; $display("FAIL taken_hold_idle: got %b want 1", bus.taken); end
      pulse(2'd1, 4'd0, 5'b00000, 8'hF8, 16'd0, 1'b0);
      n_cmp++; if (bus.pc !== 16'h0009) begin n_fail++; $display("FAIL br_not_pc: got %h want 0009", bus.pc); end
      n_cmp++; if (bus.taken !== 1'b0) begin n_fail++; $display("FAIL br_not_flag: got %b want 0", bus.taken); end
      set_pc(16'h0200);
      pulse(2'd1, 4'he, 5'd0, 8'h7F, 16'd0, 1'b0);
      n_cmp++; if (bus.pc !== 16'h027F) begin n_fail++; $display("FAIL br_plus127: got %h want 027F", bus.pc); end
      set_pc(16'h0200);
      pulse(2'd1, 4'he, 5'd0, 8'h80, 16'd0, 1'b0);
      n_cmp++; if (bus.pc !== 16'h0180) begin n_fail++; $display("FAIL br_minus128: got %h want 0180", bus.pc); end
      pulse(2'd3, 4'he, 5'd0, 8'h10, 16'h0033, 1'b1);
      n_cmp++; if (bus.pc !== 16'h0180 || bus.taken !== 1'b0) begin n_fail++; $display("FAIL mode_hold: got pc %h taken %b want 0180 0", bus.pc, bus.taken); end
   endtask

   task automatic test_jump_link();
      set_pc(16'h0020);
      pulse(2'd2, 4'he, 5'd0, 8'd0, 16'h0100, 1'b1);
      n_cmp++; if (bus.pc !== 16'h0100) begin n_fail++; $display("FAIL jal_pc: got %h want 0100", bus.pc); end
      n_cmp++; if (bus.link !== 16'h0021) begin n_fail++; $display("FAIL jal_link: got %h want 0021", bus.link); end
      n_cmp++; if (bus.taken !== 1'b1) begin n_fail++; $display("FAIL jal_taken: got %b want 1", bus.taken); end
      set_pc(16'h0030);
      pulse(2'd2, 4'hf, 5'h1F, 8'd0, 16'h0100, 1'b1);
      n_cmp++; if (bus.pc !== 16'h0031) begin n_fail++; $display("FAIL jnever_pc: got %h want 0031", bus.pc); end
      n_cmp++; if (bus.link !== 16'h0021) begin n_fail++; $display("FAIL jnever_link: got %h want 0021", bus.link); end
      n_cmp++; if (bus.taken !== 1'b0) begin n_fail++; $display("FAIL jnever_taken: got %b want 0", bus.taken); end
   endtask

   task automatic test_cond_sweep();
      logic [15:0] exp_lo = 16'h56AA;
      logic [15:0] exp_hi = 16'h6955;
      for (int p = 0; p < 2; p++) begin
         for (int c = 0; c < 16; c++) begin
            logic       want = (p == 0) ? exp_lo[c] : exp_hi[c];
            logic [4:0] fl   = (p == 0) ? 5'b00000 : 5'b11111;
            set_pc(16'h0040);
            pulse(2'd1, 4'(c), fl, 8'h04, 16'd0, 1'b0);
            n_cmp++; if (bus.taken !== want || bus.pc !== (want ? 16'h0044 : 16'h0041)) begin
               n_fail++; $display("FAIL cond_%0d_flags_%b: got taken %b pc %h want taken %b", c, fl, bus.taken, bus.pc, want);
            end
         end
      end
   endtask

   task automatic test_wrap_and_async_reset();
`ifndef PC_BOUNDS_EN
      set_pc(16'hFFFF);
      n_cmp++; if (bus.pc_plus1 !== 16'h0000) begin n_fail++; $display("FAIL wrap_plus1: got %h want 0000", bus.pc_plus1); end
      pulse(2'd0, 4'd0, 5'd0, 8'd0, 16'd0, 1'b0);
      n_cmp++; if (bus.pc !== 16'h0000) begin n_fail++; $display("FAIL wrap_inc: got %h want 0000", bus.pc); end
      set_pc(16'h0002);
      pulse(2'd1, 4'he, 5'd0, 8'hFC, 16'd0, 1'b0);
      n_cmp++; if (bus.pc !== 16'hFFFE) begin n_fail++; $display("FAIL wrap_back: got %h want FFFE", bus.pc); end
`endif
      set_pc(16'h0055);
      @(negedge clk);
      bus.pc_en = 1'b1; bus.mode = 2'd2; bus.cond = 4'he; bus.target = 16'h0077; bus.link_en = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      n_cmp++; if (bus.pc !== RESET_ADDR || bus.taken !== 1'b0) begin n_fail++; $display("FAIL async_reset: got pc %h taken %b want %h 0", bus.pc, bus.taken, RESET_ADDR); end
      @(posedge clk); #1;
      n_cmp++; if (bus.pc !== RESET_ADDR || bus.link !== 16'h0) begin n_fail++; $display("FAIL reset_overrides_en: got pc %h link %h", bus.pc, bus.link); end
      bus.pc_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         logic [15:0] tg = (($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 16'h03FF)));
         pulse(2'($urandom), 4'($urandom), 5'($urandom), 8'($urandom), tg, 1'($urandom));
         repeat ($urandom_range(0, 2)) @(posedge clk);
         #1;
         n_cmp++; if (bus.pc !== m_pc || bus.taken !== m_taken || bus.link !== m_link ||
                      bus.pc_plus1 !== m_pc + 16'd1 || bus.fault !== m_fault) begin
            n_fail++;
            $display("FAIL rand_%0d: got pc %h tk %b lk %h f %b want pc %h tk %b lk %h f %b",
                     i, bus.pc, bus.taken, bus.link, bus.fault, m_pc, m_taken, m_link, m_fault);
         end
      end
   endtask

`ifdef PC_BOUNDS_EN
   task automatic test_bounds();
      apply_reset();
      set_pc(16'h03FF);
      pulse(2'd0, 4'd0, 5'd0, 8'd0, 16'd0, 1'b0);
      n_cmp++; if (bus.pc !== TRAP_ADDR || bus.fault !== 1'b1 || bus.taken !== 1'b1) begin
         n_fail++; $display("FAIL bounds_trap: got pc %h fault %b taken %b want %h 1 1", bus.pc, bus.fault, bus.taken, TRAP_ADDR);
      end
      pulse(2'd0, 4'd0, 5'd0, 8'd0, 16'd0, 1'b0);
      n_cmp++; if (bus.fault !== 1'b1 || bus.taken !== 1'b0) begin n_fail++; $display("FAIL bounds_sticky: got fault %b taken %b want 1 0", bus.fault, bus.taken); end
      apply_reset();
      #1;
      n_cmp++; if (bus.fault !== 1'b0) begin n_fail++; $display("FAIL bounds_clear: got %b want 0", bus.fault); end
   endtask
`endif

   initial begin
      test_reset();
      test_increment();
      test_branch();
      test_jump_link();
      test_cond_sweep();
      test_wrap_and_async_reset();
      test_random();
`ifdef PC_BOUNDS_EN
      test_bounds();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
